// File: rtl/pwm_capture.sv
// PWM duty-cycle recovery: synchronizes a PWM stream, measures the high time of each
// nominal 2^BITS-clock period, tracks lock, and flags flat (stuck) inputs and silence.
module pwm_capture #(
    parameter int unsigned BITS         = 6,
    parameter int unsigned LOCK_PERIODS = 4,
    parameter int unsigned SIL_LENGTH   = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            pwm_in,
    output logic [BITS-1:0] level,
    output logic            level_valid,
    output logic            locked,
    output logic            period_err,
    output logic            sil
);

    localparam int unsigned CW = BITS + 1;
    localparam int unsigned SW = SIL_LENGTH + 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] NOMINAL  = CW'(2**BITS);
    localparam logic [CW-1:0] TIMEOUT  = CW'(2**BITS + 1);
    localparam logic [SW-1:0] SIL_MAX  = SW'(2**SIL_LENGTH);
    localparam logic [3:0]    GOOD_MAX = 4'(LOCK_PERIODS);

    typedef enum logic [1:0] {ACQUIRE, MEASURE, FLAT} state_t;

    logic            s1_q, s2_q, s3_q;
    logic            rise;
    state_t          state_q, state_d;
    logic [CW-1:0]   period_q, period_d;
    logic [CW-1:0]   high_q, high_d;
    logic [BITS-1:0] flat_q, flat_d;
    logic [BITS-1:0] level_q, level_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            locked_q, locked_d;
    logic [3:0]      good_q, good_d;
    logic [SW-1:0]   same_q, same_d;
    logic            emit;
    logic [BITS-1:0] sample;

    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d  = state_q;
        period_d = (period_q == CNT_MAX) ? period_q : period_q + 1'b1;
        high_d   = (s2_q && high_q != CNT_MAX) ? high_q + 1'b1 : high_q;
        flat_d   = flat_q + 1'b1;
        level_d  = level_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        good_d   = good_q;
        same_d   = same_q;
        emit     = 1'b0;
        sample   = '0;

        if (rise) begin
            period_d = CW'(1);
            high_d   = CW'(1);
        end

        unique case (state_q)
            ACQUIRE: begin
                if (rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    if (period_q == NOMINAL) begin
                        emit   = 1'b1;
                        sample = high_q[BITS-1:0];
                        good_d = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
                        if (good_d == GOOD_MAX) locked_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end else if (period_q == TIMEOUT) begin
                    state_d = FLAT;
                    emit    = 1'b1;
                    sample  = s2_q ? '1 : '0;
                    flat_d  = BITS'(1);
                end
            end
            FLAT: begin
                if (rise) begin
                    state_d = MEASURE;
                end else if (flat_q == '0) begin
                    // flat_q wraps every 2^BITS clocks after the entry sample
                    emit   = 1'b1;
                    sample = s2_q ? '1 : '0;
                end
            end
            default: state_d = ACQUIRE;
        endcase

        if (emit) begin
            valid_d = 1'b1;
            level_d = sample;
            if (sample == level_q)
                same_d = (same_q == SIL_MAX) ? same_q : same_q + 1'b1;
            else
                same_d = SW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= ACQUIRE;
            period_q <= '0;
            high_q   <= '0;
            flat_q   <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            good_q   <= '0;
            same_q   <= '0;
        end else begin
            s1_q     <= pwm_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
            flat_q   <= flat_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            good_q   <= good_d;
            same_q   <= same_d;
        end
    end

    assign level       = level_q;
    assign level_valid = valid_q;
    assign period_err  = err_q;
    assign locked      = locked_q;
    assign sil         = (same_q == SIL_MAX);

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes hand-computed expected events,
// a negedge monitor pops and compares whenever level_valid or period_err fires.
module tb_pwm_capture;

    localparam int KIND_NONE = 0;
    localparam int KIND_SMP  = 1;
    localparam int KIND_ERR  = 2;

    typedef struct {
        int kind;
        int cyc;
        int lvl;
        bit lk;
        bit sl;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       pwm;
    logic [5:0] level;
    logic       level_valid;
    logic       locked;
    logic       period_err;
    logic       sil;

    int   cyc;
    int   tests;
    int   fails;
    int   hold_lvl;
    exp_t q[$];

    pwm_capture #(.BITS(6), .LOCK_PERIODS(4), .SIL_LENGTH(4)) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .pwm_in     (pwm),
        .level      (level),
        .level_valid(level_valid),
        .locked     (locked),
        .period_err (period_err),
        .sil        (sil)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input int kind, input int c, input int lvl, input bit lk, input bit sl);
        exp_t e;
        e.kind = kind; e.cyc = c; e.lvl = lvl; e.lk = lk; e.sl = sl;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One PWM period starting now; the expected event is what this rising edge produces.
    task automatic pwm_period(input int high, input int period, input int kind,
                              input int lvl, input bit lk, input bit sl);
        if (kind != KIND_NONE) push(kind, cyc + 3, lvl, lk, sl);
        pwm = 1'b1;
        repeat (high) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (period - high) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_lvl = 0;
        end else if (level_valid || period_err) begin
            if (level_valid && period_err) begin
                tests++; fails++;
                $display("FAIL valid_err_overlap at cyc %0d", cyc);
            end
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: cyc=%0d valid=%0b err=%0b level=%0d",
                         cyc, level_valid, period_err, level);
            end else begin
                exp_t e;
                int   kind;
                e = q.pop_front();
                kind = level_valid ? KIND_SMP : KIND_ERR;
                if (kind != e.kind || cyc != e.cyc || int'(level) != e.lvl ||
                    locked != e.lk || sil != e.sl) begin
                    fails++;
                    $display("FAIL event: got kind=%0d cyc=%0d level=%0d locked=%0b sil=%0b, expected kind=%0d cyc=%0d level=%0d locked=%0b sil=%0b",
                             kind, cyc, level, locked, sil, e.kind, e.cyc, e.lvl, e.lk, e.sl);
                end
                if (e.kind == KIND_SMP) hold_lvl = e.lvl;
            end
        end else begin
            tests++;
            if (int'(level) != hold_lvl) begin
                fails++;
                $display("FAIL level_hold: cyc=%0d got %0d expected %0d", cyc, level, hold_lvl);
            end
        end
    end

    initial begin
        int t0;
        tests = 0; fails = 0; hold_lvl = 0;
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", int'(level), 0);
        check("rst_valid", int'(level_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(period_err), 0);
        check("rst_sil", int'(sil), 0);
        rst_n = 1'b1;

        // Idle low input: nothing may be emitted.
        repeat (500) @(posedge clk);
        #1;
        check("idle_locked", int'(locked), 0);

        // Six 64/20 periods: first edge silent, lock with the 4th strobe.
        pwm_period(20, 64, KIND_NONE, 0, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 1, 0);
        pwm_period(20, 64, KIND_SMP, 20, 1, 0);

        // Short 63-clock period, then relock after four good periods.
        pwm_period(20, 63, KIND_SMP, 20, 1, 0);
        pwm_period(20, 64, KIND_ERR, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 1, 0);

        // Input stuck high: flat samples of 63 every 64 clocks, lock retained.
        t0 = cyc;
        push(KIND_SMP, t0 + 3, 20, 1, 0);
        push(KIND_SMP, t0 + 68, 63, 1, 0);
        push(KIND_SMP, t0 + 132, 63, 1, 0);
        push(KIND_SMP, t0 + 196, 63, 1, 0);
        pwm = 1'b1;
        repeat (210) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        pwm_period(20, 64, KIND_NONE, 0, 0, 0);

        // Silence detection on 16 identical samples of 32, cleared by 33.
        pwm_period(32, 64, KIND_SMP, 20, 1, 0);
        for (int k = 1; k <= 16; k++)
            pwm_period(32, 64, KIND_SMP, 32, 1, (k == 16));
        pwm_period(33, 64, KIND_SMP, 32, 1, 1);
        pwm_period(20, 64, KIND_SMP, 33, 1, 0);

        // Asynchronous reset in the middle of a locked period.
        push(KIND_SMP, cyc + 3, 20, 1, 0);
        pwm = 1'b1;
        repeat (20) @(posedge clk);
        #1 pwm = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_valid", int'(level_valid), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_err", int'(period_err), 0);
        check("mid_rst_sil", int'(sil), 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pwm_period(20, 64, KIND_NONE, 0, 0, 0);
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        t0 = cyc;
        pwm_period(20, 64, KIND_SMP, 20, 0, 0);
        // No further edge: timeout into flat with the input low.
        push(KIND_SMP, t0 + 68, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++; fails++;
            $display("FAIL missing_event: expected kind=%0d at cyc=%0d level=%0d, got none",
                     e.kind, e.cyc, e.lvl);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter BITS, default 6: sample resolution; nominal PWM period is 2^BITS clocks.
REQ-002 Parameter LOCK_PERIODS, default 4: consecutive good periods needed to assert locked (range 1..15).
REQ-003 Parameter SIL_LENGTH, default 4: sil asserts after 2^SIL_LENGTH consecutive identical samples.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pwm_in  input  1  asynchronous PWM stream from the audio PWM generator or an external pin.
REQ-007 level  output  BITS  last recovered duty-cycle sample (high-time in clocks).
REQ-008 level_valid  output  1  one-cycle strobe; level updated this cycle.
REQ-009 locked  output  1  stream tracked at nominal period.
REQ-010 period_err  output  1  one-cycle strobe; measured period not equal to 2^BITS.
REQ-011 sil  output  1  level unchanged for 2^SIL_LENGTH consecutive samples.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-013 Period counter and high counter SHALL each be BITS+1 bits wide and saturate at 2^(BITS+1)-1.
REQ-014 High counter SHALL increment each cycle s2 = 1, and SHALL reload to 1 on rise.
REQ-015 Period counter SHALL increment each cycle and SHALL reload to 1 on rise.
REQ-016 FSM states: ACQUIRE, MEASURE, FLAT; reset state ACQUIRE.
REQ-017 ACQUIRE: no samples are emitted; on rise go to MEASURE and reload both counters.
REQ-018 MEASURE, rise with period count == 2^BITS: next cycle, level <= high count[BITS-1:0] and level_valid = 1.
REQ-019 MEASURE, rise with period count != 2^BITS: next cycle, period_err = 1 and level_valid = 0; locked deasserts, good counter clears, and the FSM stays in MEASURE.
REQ-020 MEASURE, no rise by the time period count reaches 2^BITS+1: go to FLAT.
REQ-021 On entry to FLAT, emit one sample, then one sample every 2^BITS clocks while in FLAT.
REQ-022 FLAT sample value: all-ones if s2 = 1, else 0; locked is unchanged.
REQ-023 FLAT, rise: go to MEASURE and reload both counters; no sample is emitted for that edge.
REQ-024 Latency: level_valid SHALL rise on the 3rd clock edge after pwm_in is first sampled high at a period boundary.
REQ-025 Good counter SHALL increment on each REQ-018 sample and saturate at LOCK_PERIODS.
REQ-026 locked SHALL assert on the cycle the good counter reaches LOCK_PERIODS.
REQ-027 Same-level counter: on each emitted sample, increment (saturating at 2^SIL_LENGTH) if the new level equals the previous level, else reload to 1.
REQ-028 sil SHALL be 1 exactly while the same-level counter == 2^SIL_LENGTH, updating in the same cycle as level_valid.
REQ-029 level_valid and period_err SHALL never be high in the same cycle.
REQ-030 Between samples, level SHALL hold its value.

Reset
REQ-031 reset_n low SHALL immediately force level = 0, level_valid = 0, locked = 0, period_err = 0 and sil = 0.
REQ-032 reset_n low SHALL also clear all counters and synchronizer flops and set FSM = ACQUIRE, including mid-period.
REQ-033 After reset_n deasserts, the first rise SHALL only start measurement and SHALL NOT emit a sample.

Verification
REQ-034 Reset, hold pwm_in = 0 for 500 clocks -> no level_valid, locked = 0, state ACQUIRE.
REQ-035 Period 64, high 20, 6 periods -> 5 strobes with level = 20, each 64 clocks apart; locked rises with the 4th strobe.
REQ-036 After lock, one period of 63 clocks -> one period_err pulse, no level_valid for that edge, locked = 0; relock after 4 good periods.
REQ-037 After lock, hold pwm_in = 1 -> FLAT, level = 63 strobed every 64 clocks, locked stays 1; resume PWM -> first edge silent, then normal samples.
REQ-038 16 identical samples (level = 32) -> sil = 1 with the 16th strobe; one sample with level = 33 -> sil = 0 in that strobe cycle.
REQ-039 reset_n pulsed low mid-period while locked -> all outputs 0 asynchronously; the next edge produces no sample.
